score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Game-side producer of the 8-bit score that the on-board point counter displays on HEX5/HEX4.
//  Accumulates hit/miss events from the whack game FSM into a saturating binary score.
//  Converts the score to two BCD digits with a sequential shift-add converter, so the
//    display path needs no divide or modulo.
//  Keeps a session high score.
// PARAMETERS
//  MAX_SCORE     99  saturation ceiling; must be <= 99 (two decimal digits)
//  HIT_POINTS     1  points added per hit
//  MISS_PENALTY   1  points removed per miss
// PORTS
//  Clock       in   1  system clock (50 MHz); all state updates on posedge
//  Resetn      in   1  asynchronous, active-low reset
//  start       in   1  1-cycle pulse: begin a new game
//  hit         in   1  1-cycle pulse: mole hit
//  miss        in   1  1-cycle pulse: mole missed
//  game_over   in   1  1-cycle pulse: timer expired
//  score       out  8  binary score, feeds the point counter's data input
//  tens        out  4  BCD tens digit of score
//  ones        out  4  BCD ones digit of score
//  bcd_valid   out  1  high when tens/ones match the current score
//  high_score  out  8  best final score since reset
//  new_high    out  1  last finished game set a new high score
//  state       out  2  FSM state: 00 IDLE, 01 PLAY, 10 DONE
// BEHAVIOUR
//  Reset (async, Resetn=0): all outputs and registers are 0, except bcd_valid=1 (score 0 = BCD 00).
//    Any in-flight conversion is aborted.
//  FSM transitions:
//    IDLE -start-> PLAY
//    PLAY -game_over-> DONE
//    DONE -start-> PLAY
//    Any other input holds the current state.
//  Entering PLAY: score<=0 and new_high<=0 on the same edge.
//  start while in PLAY is ignored.
//  hit/miss are acted on only in PLAY; in IDLE/DONE they are ignored.
//  Score update per edge in PLAY:
//    hit only:    score <= min(score+HIT_POINTS, MAX_SCORE)
//    miss only:   score <= (score<MISS_PENALTY) ? 0 : score-MISS_PENALTY
//    hit & miss:  score unchanged (no conversion started)
//  Score arithmetic is 9-bit internally, so the saturation compare cannot wrap.
//  game_over with hit/miss on the same edge:
//    the score update is applied;
//    the DONE transition happens on the same edge;
//    the high-score compare uses the updated score on the next edge.
//  On the first cycle in DONE:
//    if score > high_score then high_score<=score and new_high<=1.
//    Equal scores do not set new_high.
//  Conversion latency:
//    Trigger: score changes at edge N.
//    Edge N: bcd_valid<=0.
//    Edges N+1..N+8: one shift-add iteration each (8 iterations).
//    Edge N+8: tens/ones load and bcd_valid<=1.
//    tens/ones hold their previous values during conversion and never show partial results.
//  Score changes again mid-conversion:
//    restart from the new score; bcd_valid stays 0.
//    Only the final score is ever presented.
//  score is valid every cycle and is independent of bcd_valid.
// STRUCTURE
//  score_defs.vh (shared include):
//    state encodings S_IDLE/S_PLAY/S_DONE;
//    SCORE_W=8;
//    BCD_ITER=8.
//  Sub-module bin2bcd_seq:
//    ports Clock, Resetn, load, bin[7:0], busy, done, bcd[11:0];
//    double-dabble, one iteration per clock;
//    a load while busy restarts the conversion.
//  Top level: FSM, saturating score register, high-score register, output registers.
// TESTING
//  Reset, then start, then 3 hits -> score=3; tens=0/ones=3 with bcd_valid=1 8 cycles after the 3rd hit.
//  Score 0, then miss -> score stays 0; no conversion started (bcd_valid stays 1).
//  120 hits -> score saturates at 99; tens=9, ones=9.
//  hit and miss on the same cycle at score 5 -> score=5; bcd_valid unaffected.
//  hit, then hit 3 cycles later -> bcd_valid low until 8 cycles after the 2nd hit; tens/ones go 00->02, never 01.
//  Game 1 ends at 12 -> high_score=12, new_high=1.
//    start -> new_high=0.
//    Game 2 ends at 12 -> new_high=0.
//    Resetn low mid-game -> all outputs 0, bcd_valid=1, state=IDLE.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: shared state encoding, widths and the double-dabble step for the score display path
package score_keeper_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_DONE = 2'b10} state_t;
    localparam int SCORE_W = 8;
    localparam int BCD_W = 12;
    localparam int BCD_ITER = 8;
    localparam int SH_W = BCD_W + SCORE_W;
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] t;
        t = sh;
        for (int d = 0; d < BCD_W / 4; d++)
            if (t[SCORE_W+4*d +: 4] >= 4'd5) t[SCORE_W+4*d +: 4] = t[SCORE_W+4*d +: 4] + 4'd3;
        return {t[SH_W-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: game events from the whack FSM in, score and display digits out
interface score_keeper_if;
    import score_keeper_pkg::*;
    logic start;
    logic hit;
    logic miss;
    logic game_over;
    logic [SCORE_W-1:0] score;
    logic [3:0] tens;
    logic [3:0] ones;
    logic bcd_valid;
    logic [SCORE_W-1:0] high_score;
    logic new_high;
    state_t state;
    modport master (
        output start, hit, miss, game_over,
        input score, tens, ones, bcd_valid, high_score, new_high, state
    );
    modport slave (
        input start, hit, miss, game_over,
        output score, tens, ones, bcd_valid, high_score, new_high, state
    );
endinterface

// File: rtl/score_keeper_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one iteration per clock; a load while busy restarts
module bin2bcd_seq
    import score_keeper_pkg::*;
(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               load,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);
    logic [SH_W-1:0] sh;
    logic [SH_W-1:0] sh_nx;
    logic [$clog2(BCD_ITER)-1:0] cnt;
    assign sh_nx = dd_step(sh);
    // done marks the edge that performs the last iteration; bcd is that iteration's result
    assign done = busy && cnt == ($clog2(BCD_ITER))'(BCD_ITER - 1);
    assign bcd = sh_nx[SH_W-1:SCORE_W];
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sh <= '0;
            cnt <= '0;
            busy <= 1'b0;
        end else if (load) begin
            sh <= {{BCD_W{1'b0}}, bin};
            cnt <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sh <= sh_nx;
            cnt <= cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: game FSM, saturating score, session high score and BCD digits for the HEX display
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int MAX_SCORE = 99,
    parameter int HIT_POINTS = 1,
    parameter int MISS_PENALTY = 1
) (
    input logic           Clock,
    input logic           Resetn,
    score_keeper_if.slave sk
);
    state_t state_q;
    state_t state_nx;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_nx;
    logic [SCORE_W-1:0] high_q;
    logic [SCORE_W:0] sum;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic new_high_q;
    logic settle_q;
    logic bcd_valid_q;
    logic in_play;
    logic enter_play;
    logic load;
    logic busy;
    logic done;
    logic [BCD_W-1:0] bcd;
    logic beat_high;
    always_comb begin
        in_play = state_q == S_PLAY;
        enter_play = sk.start && (state_q == S_IDLE || state_q == S_DONE);
        state_nx = state_q;
        if (enter_play) state_nx = S_PLAY;
        else if (in_play && sk.game_over) state_nx = S_DONE;
    end
    always_comb begin
        sum = {1'b0, score_q} + (SCORE_W+1)'(HIT_POINTS);
        score_nx = enter_play ? '0
                 : (!in_play || sk.hit == sk.miss) ? score_q
                 : sk.hit ? (sum > (SCORE_W+1)'(MAX_SCORE) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0])
                 : (score_q < SCORE_W'(MISS_PENALTY) ? '0 : score_q - SCORE_W'(MISS_PENALTY));
        load = score_nx != score_q;
        beat_high = settle_q && score_q > high_q;
    end
    bin2bcd_seq u_bcd (
        .Clock  (Clock),
        .Resetn (Resetn),
        .load   (load),
        .bin    (score_nx),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            score_q <= '0;
            high_q <= '0;
            new_high_q <= 1'b0;
            settle_q <= 1'b0;
            bcd_valid_q <= 1'b1;
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            state_q <= state_nx;
            score_q <= score_nx;
            settle_q <= in_play && sk.game_over;
            if (beat_high) high_q <= score_q;
            new_high_q <= enter_play ? 1'b0 : beat_high ? 1'b1 : new_high_q;
            // a fresh load supersedes a conversion finishing on the same edge
            bcd_valid_q <= load ? 1'b0 : done ? 1'b1 : bcd_valid_q;
            if (done && !load) {tens_q, ones_q} <= |bcd[BCD_W-1:8] ? 8'h99 : bcd[7:0];
        end
    end
    assign sk.score = score_q;
    assign sk.tens = tens_q;
    assign sk.ones = ones_q;
    assign sk.bcd_valid = bcd_valid_q && !busy;
    assign sk.high_score = high_q;
    assign sk.new_high = new_high_q;
    assign sk.state = state_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed checks of score_keeper against a rule-level model
module tb_score_keeper;
    localparam int MAX = 99;
    localparam int HP = 1;
    localparam int MP = 1;
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #10 Clock = ~Clock;
    score_keeper_if sk ();
    score_keeper #(.MAX_SCORE(MAX), .HIT_POINTS(HP), .MISS_PENALTY(MP)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .sk     (sk)
    );
    int checks = 0;
    int failures = 0;
    int m_state, m_score, m_high, m_age, m_disp;
    bit m_newhigh, m_judge;

    function automatic logic [27:0] obs();
        return {sk.score, sk.tens, sk.ones, sk.bcd_valid, sk.high_score, sk.new_high, sk.state};
    endfunction
    function automatic logic [27:0] exp_v();
        return {8'(m_score), 4'(m_disp / 10), 4'(m_disp % 10), (m_age >= 8), 8'(m_high), m_newhigh, 2'(m_state)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_newhigh = 0; m_judge = 0; m_age = 8; m_disp = 0;
    endtask

    // drive one clock of events and advance the reference model by the game rules
    task automatic tick(input bit s, input bit h, input bit m, input bit g);
        int ns;
        sk.start = s; sk.hit = h; sk.miss = m; sk.game_over = g;
        @(posedge Clock);
        if (m_judge && m_score > m_high) begin m_high = m_score; m_newhigh = 1; end
        m_judge = 0;
        ns = m_score;
        if (m_state == 1 && h && !m) ns = (m_score + HP > MAX) ? MAX : m_score + HP;
        if (m_state == 1 && m && !h) ns = (m_score < MP) ? 0 : m_score - MP;
        if (s && m_state != 1) begin ns = 0; m_newhigh = 0; m_state = 1; end
        else if (m_state == 1 && g) begin m_state = 2; m_judge = 1; end
        m_age = (ns != m_score) ? 0 : (m_age < 8 ? m_age + 1 : 8);
        if (m_age == 8) m_disp = ns;
        m_score = ns;
        #1;
        sk.start = 0; sk.hit = 0; sk.miss = 0; sk.game_over = 0;
    endtask

    task automatic do_reset();
        #3 Resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== {8'd0, 4'd0, 4'd0, 1'b1, 8'd0, 1'b0, 2'd0}) begin
            failures++; $display("FAIL reset_async: got %h exp %h", obs(), {8'd0, 4'd0, 4'd0, 1'b1, 8'd0, 1'b0, 2'd0});
        end
        @(negedge Clock) Resetn = 1'b1;
    endtask

    task automatic test_reset();
        sk.start = 0; sk.hit = 0; sk.miss = 0; sk.game_over = 0;
        repeat (3) @(negedge Clock);
        do_reset();
        tick(0, 1, 1, 0);
        checks++;
        if (obs() !== exp_v()) begin failures++; $display("FAIL reset_idle: got %h exp %h", obs(), exp_v()); end
    endtask

    task automatic test_hits();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        checks++;
        if (sk.score !== 8'd3 || sk.bcd_valid !== 1'b0) begin
            failures++; $display("FAIL hits_score: got %0d/%b exp 3/0", sk.score, sk.bcd_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs() !== exp_v()) begin failures++; $display("FAIL hits_wait%0d: got %h exp %h", k, obs(), exp_v()); end
        end
        checks++;
        if ({sk.tens, sk.ones, sk.bcd_valid} !== {4'd0, 4'd3, 1'b1}) begin
            failures++; $display("FAIL hits_bcd: got %h%h v=%b exp 03 v=1", sk.tens, sk.ones, sk.bcd_valid);
        end
    endtask

    task automatic test_miss_zero();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
        repeat (9) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        checks++;
        if (sk.score !== 8'd0 || sk.bcd_valid !== 1'b1) begin
            failures++; $display("FAIL miss_zero: got %0d/%b exp 0/1", sk.score, sk.bcd_valid);
        end
        checks++;
        if (obs() !== exp_v()) begin failures++; $display("FAIL miss_zero_model: got %h exp %h", obs(), exp_v()); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 120; i++) begin
            tick(0, 1, 0, 0);
            checks++;
            if (obs() !== exp_v()) begin failures++; $display("FAIL sat_hit%0d: got %h exp %h", i, obs(), exp_v()); end
        end
        repeat (8) tick(0, 0, 0, 0);
        checks++;
        if ({sk.score, sk.tens, sk.ones, sk.bcd_valid} !== {8'd99, 4'd9, 4'd9, 1'b1}) begin
            failures++; $display("FAIL saturate: got %0d %h%h v=%b exp 99 99 v=1", sk.score, sk.tens, sk.ones, sk.bcd_valid);
        end
    endtask

    task automatic test_hit_miss();
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        repeat (9) tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        checks++;
        if ({sk.score, sk.tens, sk.ones, sk.bcd_valid} !== {8'd5, 4'd0, 4'd5, 1'b1}) begin
            failures++; $display("FAIL hit_miss: got %0d %h%h v=%b exp 5 05 v=1", sk.score, sk.tens, sk.ones, sk.bcd_valid);
        end
        checks++;
        if (obs() !== exp_v()) begin failures++; $display("FAIL hit_miss_model: got %h exp %h", obs(), exp_v()); end
    endtask

    task automatic test_retrigger();
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
        repeat (9) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            tick(0, 0, 0, 0);
            checks++;
            if ({sk.tens, sk.ones} === 8'h01 || sk.bcd_valid !== (k >= 8)) begin
                failures++; $display("FAIL retrig%0d: got %h%h v=%b", k, sk.tens, sk.ones, sk.bcd_valid);
            end
            checks++;
            if (obs() !== exp_v()) begin failures++; $display("FAIL retrig_model%0d: got %h exp %h", k, obs(), exp_v()); end
        end
        checks++;
        if ({sk.tens, sk.ones} !== 8'h02) begin failures++; $display("FAIL retrig_final: got %h%h exp 02", sk.tens, sk.ones); end
    endtask

    task automatic test_high_score();
        do_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        checks++;
        if ({sk.high_score, sk.new_high, sk.state} !== {8'd12, 1'b1, 2'b10}) begin
            failures++; $display("FAIL high_game1: got %0d nh=%b st=%b exp 12 nh=1 st=10", sk.high_score, sk.new_high, sk.state);
        end
        tick(1, 0, 0, 0);
        checks++;
        if (sk.new_high !== 1'b0 || sk.score !== 8'd0) begin
            failures++; $display("FAIL high_restart: got nh=%b score=%0d exp nh=0 score=0", sk.new_high, sk.score);
        end
        for (int i = 0; i < 12; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        checks++;
        if ({sk.high_score, sk.new_high} !== {8'd12, 1'b0}) begin
            failures++; $display("FAIL high_equal: got %0d nh=%b exp 12 nh=0", sk.high_score, sk.new_high);
        end
        checks++;
        if (obs() !== exp_v()) begin failures++; $display("FAIL high_model: got %h exp %h", obs(), exp_v()); end
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        do_reset();
    endtask

    task automatic test_random();
        bit s, h, m, g;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom % 25) == 0;
            h = ($urandom % 100) < 40;
            m = ($urandom % 100) < 20;
            g = ($urandom % 50) == 0;
            tick(s, h, m, g);
            checks++;
            if (obs() !== exp_v()) begin failures++; $display("FAIL random%0d: got %h exp %h", i, obs(), exp_v()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hits();
        test_miss_zero();
        test_saturate();
        test_hit_miss();
        test_retrigger();
        test_high_score();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
